// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
// Shared types for the accelerator PIO host initiator:
//   hs_sig_t  - 2-bit handshake codes on to_hw_sig / to_sw_sig
//   err_t     - abort reason reported on err_code
//   state_t   - initiator FSM state (also exported as the debug encoding)
// Helpers map a state to the handshake code it drives and flag the states
// that wait on the accelerator (watchdog-supervised).
// ---------------------------------------------------------------------------
package acc_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_ACK  = 2'd2,
        HS_RST  = 2'd3
    } hs_sig_t;

    typedef enum logic [1:0] {
        E_NONE = 2'd0,
        E_LEN  = 2'd1,
        E_TMO  = 2'd2,
        E_RST  = 2'd3
    } err_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PUT   = 4'd1,
        S_HOLD  = 4'd2,
        S_START = 4'd3,
        S_DACK  = 4'd4,
        S_FIN   = 4'd5,
        S_KICK  = 4'd6,
        S_RWAIT = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    localparam int NUM_WORDS = 4;

    // Handshake code presented to the accelerator while in a given state.
    function automatic hs_sig_t state_sig(input state_t s);
        case (s)
            S_PUT, S_START, S_FIN: return HS_REQ;
            S_HOLD, S_DACK:        return HS_ACK;
            default:               return HS_IDLE;
        endcase
    endfunction

    // States that block on the accelerator and are bounded by the watchdog.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_PUT) || (s == S_HOLD) || (s == S_START) ||
               (s == S_DACK) || (s == S_RWAIT);
    endfunction

endpackage

// File: rtl/acc_wd_counter.sv
// ---------------------------------------------------------------------------
// acc_wd_counter
// Watchdog cycle counter. Counts enabled cycles since the last clear and
// raises o_tc on the TIMEOUT-th cycle of a wait (count == TIMEOUT-1), then
// saturates there until cleared.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_clear         restart count (state change)
//   i_enable        count this cycle
//   o_tc            terminal count reached
// ---------------------------------------------------------------------------
module acc_wd_counter #(
    parameter int TIMEOUT = 1 << 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/acc_host_initiator.sv
// ---------------------------------------------------------------------------
// acc_host_initiator
// Hardware master for the accelerator's 2-bit PIO handshake. Accepts one
// command, sends len/addr_a/addr_b/addr_s as four handshaked words, issues
// start, acknowledges done, and returns to idle. Can also pulse the
// accelerator's soft reset and wait for it to report reset.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready  command handshake
//   i_cmd_len, i_cmd_addr_*    command fields
//   i_rst_req                  request accelerator soft reset (IDLE only)
//   o_to_hw_data, o_to_hw_sig  registered word and handshake code to acc
//   i_to_sw_sig                handshake code from acc
//   o_acc_reset_n              registered active-low soft reset to acc
//   o_busy, o_done, o_err      status; done/err are one-cycle pulses
//   o_err_code                 abort reason, held until next accept
//   o_cur_state                debug state encoding
// ---------------------------------------------------------------------------
module acc_host_initiator
    import acc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 1 << 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_len,
    input  logic [DATA_W-1:0] i_cmd_addr_a,
    input  logic [DATA_W-1:0] i_cmd_addr_b,
    input  logic [DATA_W-1:0] i_cmd_addr_s,
    input  logic              i_rst_req,
    output logic [DATA_W-1:0] o_to_hw_data,
    output logic [1:0]        o_to_hw_sig,
    input  logic [1:0]        i_to_sw_sig,
    output logic              o_acc_reset_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [3:0]        o_cur_state
);

    state_t            r_state;
    logic [DATA_W-1:0] r_w [NUM_WORDS];
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_to_hw_data;
    hs_sig_t           r_to_hw_sig;
    logic              r_acc_reset_n;
    logic              r_done;
    logic              r_err;
    err_t              r_err_code;

    state_t            w_state_next;
    err_t              w_err_next;
    logic              w_idx_adv;
    logic [1:0]        w_idx_nxt;
    logic              w_accept;
    logic              w_len_bad;
    logic              w_tc;
    hs_sig_t           w_sw;

    assign w_sw      = hs_sig_t'(i_to_sw_sig);
    assign w_idx_nxt = r_idx + 2'd1;
    // Unsigned compare: huge lengths (MSB set) must be rejected, not wrap negative.
    assign w_len_bad = (i_cmd_len == '0) || (i_cmd_len > DATA_W'(MAX_LEN));
    assign w_accept  = (r_state == S_IDLE) && !i_rst_req && i_cmd_valid;

    acc_wd_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_state_next != r_state),
        .i_enable (is_wait_state(r_state)),
        .o_tc     (w_tc)
    );

    // Accelerator reporting reset (code 3) outranks normal progress, which
    // in turn outranks the watchdog so a response on the last cycle still wins.
    always_comb begin
        w_state_next = r_state;
        w_err_next   = E_NONE;
        w_idx_adv    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rst_req) begin
                    w_state_next = S_KICK;
                end else if (i_cmd_valid) begin
                    if (w_len_bad) begin
                        w_state_next = S_ERR;
                        w_err_next   = E_LEN;
                    end else begin
                        w_state_next = S_PUT;
                    end
                end
            end
            S_PUT: begin
                if (w_sw == HS_RST) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_RST;
                end else if (w_sw == HS_REQ) begin
                    w_state_next = S_HOLD;
                end else if (w_tc) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_TMO;
                end
            end
            S_HOLD: begin
                if (w_sw == HS_RST) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_RST;
                end else if (w_sw == HS_IDLE) begin
                    if (r_idx == 2'd3) begin
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_PUT;
                        w_idx_adv    = 1'b1;
                    end
                end else if (w_tc) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_TMO;
                end
            end
            S_START: begin
                if (w_sw == HS_RST) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_RST;
                end else if (w_sw == HS_REQ) begin
                    w_state_next = S_DACK;
                end else if (w_tc) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_TMO;
                end
            end
            S_DACK: begin
                if (w_sw == HS_RST) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_RST;
                end else if (w_sw == HS_IDLE) begin
                    w_state_next = S_FIN;
                end else if (w_tc) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_TMO;
                end
            end
            S_FIN: begin
                if (w_sw == HS_RST) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_RST;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_KICK: begin
                w_state_next = S_RWAIT;
            end
            S_RWAIT: begin
                if (w_sw == HS_RST) begin
                    w_state_next = S_IDLE;
                end else if (w_tc) begin
                    w_state_next = S_ERR;
                    w_err_next   = E_TMO;
                end
            end
            S_ERR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so data and sig move on the
    // same edge; a new word only ever appears together with HS_REQ.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_to_hw_data  <= '0;
            r_to_hw_sig   <= HS_IDLE;
            r_acc_reset_n <= 1'b1;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= E_NONE;
        end else begin
            r_state       <= w_state_next;
            r_to_hw_sig   <= state_sig(w_state_next);
            r_acc_reset_n <= (w_state_next != S_KICK);
            r_done        <= ((r_state == S_FIN) || (r_state == S_RWAIT)) &&
                             (w_state_next == S_IDLE);
            r_err         <= (w_state_next == S_ERR);
            if (w_accept || (w_state_next == S_ERR)) begin
                r_err_code <= w_err_next;
            end
            if (w_accept) begin
                r_idx <= 2'd0;
            end else if (w_idx_adv) begin
                r_idx <= w_idx_nxt;
            end
            if (w_accept && !w_len_bad) begin
                r_to_hw_data <= i_cmd_len;
            end else if (w_idx_adv) begin
                r_to_hw_data <= r_w[w_idx_nxt];
            end
        end
    end

    // Command words are pure data and need no reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_w[0] <= i_cmd_len;
            r_w[1] <= i_cmd_addr_a;
            r_w[2] <= i_cmd_addr_b;
            r_w[3] <= i_cmd_addr_s;
        end
    end

    assign o_cmd_ready   = (r_state == S_IDLE) && !i_rst_req && !i_reset;
    assign o_to_hw_data  = r_to_hw_data;
    assign o_to_hw_sig   = r_to_hw_sig;
    assign o_acc_reset_n = r_acc_reset_n;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign o_cur_state   = r_state;

endmodule

// File: tb/tb_acc_host_initiator.sv
// ---------------------------------------------------------------------------
// tb_acc_host_initiator
// Drives acc_host_initiator against a behavioural accelerator handshake
// model. The model records every parameter word it latches; the expected
// outcome of each command comes from the length rule and the scenario set up.
// ---------------------------------------------------------------------------
module tb_acc_host_initiator;

    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_len, cmd_addr_a, cmd_addr_b, cmd_addr_s;
    logic        rst_req;
    logic [31:0] to_hw_data;
    logic [1:0]  to_hw_sig;
    logic [1:0]  to_sw_sig;
    logic        acc_reset_n, busy, done, err;
    logic [1:0]  err_code;
    logic [3:0]  cur_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acc_host_initiator #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_len     (cmd_len),
        .i_cmd_addr_a  (cmd_addr_a),
        .i_cmd_addr_b  (cmd_addr_b),
        .i_cmd_addr_s  (cmd_addr_s),
        .i_rst_req     (rst_req),
        .o_to_hw_data  (to_hw_data),
        .o_to_hw_sig   (to_hw_sig),
        .i_to_sw_sig   (to_sw_sig),
        .o_acc_reset_n (acc_reset_n),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_err_code    (err_code),
        .o_cur_state   (cur_state)
    );

    // ---------------- accelerator handshake model ----------------
    int          m_ph;
    int          m_words;
    int          m_dly;
    int          m_fin_bad = 0;
    logic        m_stall   = 1'b0;
    logic        m_inject  = 1'b0;
    logic        m_clr     = 1'b0;
    logic [31:0] got_q[$];

    always @(posedge clk) begin
        if (reset || m_clr) begin
            m_ph      <= 0;
            m_words   <= 0;
            to_sw_sig <= 2'd0;
        end else if (!acc_reset_n) begin
            m_ph      <= 8;
            m_dly     <= $urandom_range(0, 3);
            m_words   <= 0;
            to_sw_sig <= 2'd0;
        end else begin
            case (m_ph)
                0: if (to_hw_sig == 2'd1) begin
                    got_q.push_back(to_hw_data);
                    m_words   <= m_words + 1;
                    to_sw_sig <= 2'd1;
                    m_ph      <= 1;
                end
                1: if (to_hw_sig == 2'd2) begin
                    if (m_inject && m_words == 3) begin
                        to_sw_sig <= 2'd3;
                        m_ph      <= 7;
                    end else begin
                        to_sw_sig <= 2'd0;
                        m_ph      <= (m_words == 4) ? 2 : 0;
                    end
                end
                2: if (to_hw_sig == 2'd1) begin
                    m_ph  <= 3;
                    m_dly <= $urandom_range(0, 5);
                end
                3: if (!m_stall) begin
                    if (m_dly == 0) begin
                        to_sw_sig <= 2'd1;
                        m_ph      <= 4;
                    end else begin
                        m_dly <= m_dly - 1;
                    end
                end
                4: if (to_hw_sig == 2'd2) begin
                    to_sw_sig <= 2'd0;
                    m_ph      <= 5;
                end
                // one FIN cycle of sig=1 must follow, then sig must drop to 0
                5: if (to_hw_sig == 2'd1) begin
                    m_ph <= 6;
                end else if (to_hw_sig == 2'd0) begin
                    m_fin_bad <= m_fin_bad + 1;
                    m_ph      <= 0;
                    m_words   <= 0;
                end
                6: begin
                    if (to_hw_sig != 2'd0) m_fin_bad <= m_fin_bad + 1;
                    m_ph    <= 0;
                    m_words <= 0;
                end
                7: begin
                    to_sw_sig <= 2'd0;
                    m_ph      <= 0;
                    m_words   <= 0;
                end
                8: if (m_dly == 0) begin
                    to_sw_sig <= 2'd3;
                    m_ph      <= 9;
                end else begin
                    m_dly <= m_dly - 1;
                end
                9: begin
                    to_sw_sig <= 2'd0;
                    m_ph      <= 0;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    // ---------------- reference rule ----------------
    function automatic logic [1:0] ref_len_code(input logic [31:0] len);
        return (len == 32'd0 || len > 32'(MAX_LEN)) ? 2'd1 : 2'd0;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic issue_cmd(input logic [31:0] len, ia, ib, is_, output bit ok);
        int g;
        g = 0;
        cmd_len    = len;
        cmd_addr_a = ia;
        cmd_addr_b = ib;
        cmd_addr_s = is_;
        cmd_valid  = 1'b1;
        #1;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, input int tail,
                            output int nd, output int ne, output int mx, output bit to);
        int g;
        g  = 0;
        nd = 0;
        ne = 0;
        mx = 0;
        to = 1'b1;
        while (g < budget) begin
            if (done) nd++;
            if (err) ne++;
            if (int'(to_hw_sig) > mx) mx = int'(to_hw_sig);
            if (nd + ne > 0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            g++;
        end
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            if (done) nd++;
            if (err) ne++;
        end
    endtask

    function automatic logic [31:0] rnd_len();
        return 32'($urandom_range(1, MAX_LEN));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        rst_req   = 1'b0;
        cmd_len   = 32'd4;
        repeat (3) @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_in_reset got=%b want=0", cmd_ready);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (to_hw_data !== 32'd0 || to_hw_sig !== 2'd0 || acc_reset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hw_if got data=%h sig=%0d rstn=%b want 0/0/1",
                     to_hw_data, to_hw_sig, acc_reset_n);
        end
        n_tests++;
        if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status got done=%b err=%b code=%0d want 0/0/0", done, err, err_code);
        end
        n_tests++;
        if (busy !== 1'b0 || cur_state !== 4'd0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b state=%0d ready=%b want 0/0/1",
                     busy, cur_state, cmd_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] v[4];
        int nd, ne, mx, fin0, bad;
        bit ok, to;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) begin
                v = '{32'd4, 32'h10, 32'h20, 32'h30};
            end else begin
                v[0] = rnd_len();
                v[1] = $urandom;
                v[2] = $urandom;
                v[3] = $urandom;
            end
            fin0 = m_fin_bad;
            got_q.delete();
            issue_cmd(v[0], v[1], v[2], v[3], ok);
            wait_end(2000, 3, nd, ne, mx, to);
            n_tests++;
            if (!ok || to || nd != 1 || ne != 0) begin
                n_fail++;
                $display("FAIL basic%0d_outcome got accepted=%0d timeout=%0d done=%0d err=%0d want 1/0/1/0",
                         t, ok, to, nd, ne);
            end
            bad = (got_q.size() != 4) ? 1 : 0;
            if (bad == 0)
                for (int k = 0; k < 4; k++) if (got_q[k] !== v[k]) bad = 1;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL basic%0d_words got n=%0d first=%h want n=4 first=%h",
                         t, got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, v[0]);
            end
            n_tests++;
            if (m_fin_bad != fin0) begin
                n_fail++;
                $display("FAIL basic%0d_fin_sig got violations=%0d want %0d", t, m_fin_bad, fin0);
            end
            n_tests++;
            if (err_code !== 2'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic%0d_status got code=%0d busy=%b want 0/0", t, err_code, busy);
            end
        end
    endtask

    task automatic test_len();
        logic [31:0] lens[6];
        logic [31:0] a, b, s;
        logic [1:0]  exp;
        int nd, ne, mx;
        bit ok, to;
        lens = '{32'd0, 32'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd16, 32'd1};
        for (int t = 0; t < 6; t++) begin
            a = $urandom;
            b = $urandom;
            s = $urandom;
            exp = ref_len_code(lens[t]);
            got_q.delete();
            issue_cmd(lens[t], a, b, s, ok);
            wait_end(2000, 3, nd, ne, mx, to);
            n_tests++;
            if (!ok || to || nd != ((exp == 2'd0) ? 1 : 0) || ne != ((exp == 2'd0) ? 0 : 1)) begin
                n_fail++;
                $display("FAIL len_%h_outcome got timeout=%0d done=%0d err=%0d want code %0d",
                         lens[t], to, nd, ne, exp);
            end
            n_tests++;
            if (err_code !== exp) begin
                n_fail++;
                $display("FAIL len_%h_code got=%0d want=%0d", lens[t], err_code, exp);
            end
            n_tests++;
            if (exp != 2'd0 && (mx != 0 || got_q.size() != 0)) begin
                n_fail++;
                $display("FAIL len_%h_quiet got maxsig=%0d words=%0d want 0/0",
                         lens[t], mx, got_q.size());
            end else if (exp == 2'd0 && (got_q.size() != 4 || got_q[0] !== lens[t])) begin
                n_fail++;
                $display("FAIL len_%h_words got n=%0d want 4", lens[t], got_q.size());
            end
        end
    endtask

    task automatic test_timeout();
        int g, cnt;
        bit ok;
        m_stall = 1'b1;
        got_q.delete();
        issue_cmd(rnd_len(), $urandom, $urandom, $urandom, ok);
        g = 0;
        while (!(m_words == 4 && to_hw_sig == 2'd2) && g < 500) begin
            @(negedge clk);
            g++;
        end
        cnt = 0;
        while (!err && g < 700) begin
            @(negedge clk);
            if (to_hw_sig == 2'd1) cnt++;
            g++;
        end
        n_tests++;
        if (!ok || g >= 700 || cnt != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycles got start_cycles=%0d err=%b want %0d/1", cnt, err, TIMEOUT);
        end
        n_tests++;
        if (err_code !== 2'd2 || to_hw_sig !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_code got code=%0d sig=%0d want 2/0", err_code, to_hw_sig);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_idle got busy=%b err=%b ready=%b want 0/0/1", busy, err, cmd_ready);
        end
        m_stall = 1'b0;
        m_clr   = 1'b1;
        @(negedge clk);
        m_clr = 1'b0;
    endtask

    task automatic test_rst_req();
        int low, nd, ne, mx, g;
        got_q.delete();
        rst_req   = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 32'd4;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstreq_ready got=%b want=0", cmd_ready);
        end
        @(negedge clk);
        rst_req   = 1'b0;
        cmd_valid = 1'b0;
        low = 0; nd = 0; ne = 0; mx = 0; g = 0;
        while (g < 60 && nd == 0) begin
            if (!acc_reset_n) low++;
            if (done) nd++;
            if (err) ne++;
            if (int'(to_hw_sig) > mx) mx = int'(to_hw_sig);
            if (nd == 0) @(negedge clk);
            g++;
        end
        n_tests++;
        if (low != 1) begin
            n_fail++;
            $display("FAIL rstreq_pulse got low_cycles=%0d want 1", low);
        end
        n_tests++;
        if (nd != 1 || ne != 0) begin
            n_fail++;
            $display("FAIL rstreq_done got done=%0d err=%0d want 1/0", nd, ne);
        end
        n_tests++;
        if (mx != 0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstreq_no_cmd got maxsig=%0d words=%0d want 0/0", mx, got_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_acc_rst();
        logic [31:0] v[4];
        int nd, ne, mx, bad;
        bit ok, to;
        for (int t = 0; t < 2; t++) begin
            m_inject = (t == 0);
            v[0] = rnd_len();
            v[1] = $urandom;
            v[2] = $urandom;
            v[3] = $urandom;
            got_q.delete();
            issue_cmd(v[0], v[1], v[2], v[3], ok);
            wait_end(2000, 3, nd, ne, mx, to);
            n_tests++;
            if (!ok || to || nd != t || ne != 1 - t) begin
                n_fail++;
                $display("FAIL accrst%0d_outcome got timeout=%0d done=%0d err=%0d want %0d/%0d",
                         t, to, nd, ne, t, 1 - t);
            end
            n_tests++;
            if (err_code !== ((t == 0) ? 2'd3 : 2'd0)) begin
                n_fail++;
                $display("FAIL accrst%0d_code got=%0d want=%0d", t, err_code, (t == 0) ? 3 : 0);
            end
            bad = (got_q.size() != 4 - (1 - t)) ? 1 : 0;
            if (bad == 0)
                for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== v[k]) bad = 1;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL accrst%0d_words got n=%0d want %0d", t, got_q.size(), 4 - (1 - t));
            end
        end
        m_inject = 1'b0;
    endtask

    task automatic test_back_to_back();
        int g, nd, ne, mx, bad;
        bit ok, to;
        logic [31:0] v[4];
        // abandon a transaction in START with a synchronous reset
        m_stall = 1'b1;
        issue_cmd(rnd_len(), $urandom, $urandom, $urandom, ok);
        g = 0;
        while (m_ph != 3 && g < 500) begin
            @(negedge clk);
            g++;
        end
        n_tests++;
        if (!ok || g >= 500 || to_hw_sig !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_reach_start got sig=%0d wait=%0d want sig 1", to_hw_sig, g);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (to_hw_data !== 32'd0 || to_hw_sig !== 2'd0 || acc_reset_n !== 1'b1 ||
            done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0 ||
            cur_state !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got data=%h sig=%0d rstn=%b done=%b err=%b code=%0d busy=%b st=%0d want reset values",
                     to_hw_data, to_hw_sig, acc_reset_n, done, err, err_code, busy, cur_state);
        end
        reset   = 1'b0;
        m_stall = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            v[0] = rnd_len();
            v[1] = $urandom;
            v[2] = $urandom;
            v[3] = $urandom;
            got_q.delete();
            issue_cmd(v[0], v[1], v[2], v[3], ok);
            wait_end(2000, 0, nd, ne, mx, to);
            n_tests++;
            if (!ok || to || nd != 1 || ne != 0) begin
                n_fail++;
                $display("FAIL b2b%0d_outcome got timeout=%0d done=%0d err=%0d want 0/1/0", t, to, nd, ne);
            end
            bad = (got_q.size() != 4) ? 1 : 0;
            if (bad == 0)
                for (int k = 0; k < 4; k++) if (got_q[k] !== v[k]) bad = 1;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL b2b%0d_words got n=%0d want 4", t, got_q.size());
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (m_fin_bad != 0) begin
            n_fail++;
            $display("FAIL fin_sig_total got violations=%0d want 0", m_fin_bad);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        rst_req    = 1'b0;
        cmd_len    = '0;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_addr_s = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_len();
        test_timeout();
        test_rst_req();
        test_acc_rst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached before summary, tests=%0d", n_tests);
        $fatal(1, "simulation time limit");
    end

endmodule
